// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. LSB first, idle-high line. Every bit is
//            sampled at its centre, timed from the detected start edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4); default 27 MHz / 115200
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   rx_in         serial line, asynchronous to clk
//   rx_data[7:0]  last correctly framed byte, held until the next one
//   rx_valid      one-cycle pulse when rx_data is updated
//   rx_frame_err  one-cycle pulse when the stop bit samples low
//   rx_busy       high whenever the receiver is not idle
// ============================================================================
module uart_rx #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int             CW     = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  C_FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;
   logic          rxs;

   // sync_q[1] is the metastability-filtered copy of the line
   assign rxs = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], rx_in};
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sr_d    = sr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rxs) begin
               state_d = S_START;
            end
         end

         // Re-check the line half a bit in; a high here was only a glitch.
         S_START: begin
            if (cnt_q == C_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DATA: begin
            if (cnt_q == C_FULL) begin
               cnt_d       = '0;
               sr_d[idx_q] = rxs;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Sampling the stop bit at its centre leaves half a bit of slack,
         // so a start bit that immediately follows is still seen from IDLE.
         S_STOP: begin
            if (cnt_q == C_FULL) begin
               cnt_d = '0;
               if (rxs) begin
                  data_d  = sr_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Wait out a held-low line so it is not mistaken for a new start bit.
         S_BREAK: begin
            cnt_d = '0;
            if (rxs) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         idx_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. One receiver at 16 clocks/bit
//            for the directed scenarios, one at the default rate for the
//            "hello\n" loopback. Expected bytes are queued when a frame is
//            driven and compared when the receiver reports rx_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int C_CPB    = 16;
   localparam int C_CPB_LB = 234;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_lb = 1'b1;
   logic [7:0] rx_data, rx_data_lb;
   logic       rx_valid, rx_valid_lb;
   logic       rx_frame_err, rx_frame_err_lb;
   logic       rx_busy, rx_busy_lb;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int n_valid = 0, n_ferr = 0, n_valid_lb = 0, n_ferr_lb = 0;
   int busy_run = 0, max_busy = 0;
   int start_cyc = 0, last_valid_cyc = 0;
   int nv0, nf0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_lb_q[$];
   logic [7:0] hello [6] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

   uart_rx #(.CLKS_PER_BIT(C_CPB)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .rx_in        (rx_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   uart_rx u_dut_lb (
      .clk          (clk),
      .reset        (reset),
      .rx_in        (rx_lb),
      .rx_data      (rx_data_lb),
      .rx_valid     (rx_valid_lb),
      .rx_frame_err (rx_frame_err_lb),
      .rx_busy      (rx_busy_lb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard / protocol monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else                   check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
         if (rx_frame_err) n_ferr++;
         if (rx_valid && rx_frame_err) check("valid_and_err", 32'd1, 32'd0);
         if (rx_busy) busy_run++; else busy_run = 0;
         if (busy_run > max_busy) max_busy = busy_run;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid_lb) begin
            n_valid_lb++;
            if (exp_lb_q.size() == 0) check("lb_unexpected_valid", 32'd1, 32'd0);
            else                      check("lb_rx_data", {24'd0, rx_data_lb}, {24'd0, exp_lb_q.pop_front()});
         end
         if (rx_frame_err_lb) n_ferr_lb++;
      end
   end

   // Drive one 8N1 frame; stop_v sets the stop-bit level
   task automatic send_frame(input bit lb, input int cpb, input logic [7:0] b, input bit stop_v);
      logic [9:0] bits;
      bits = {stop_v, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (lb) rx_lb = bits[i];
         else    rx_in = bits[i];
         if (!lb && i == 0) start_cyc = cyc;
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data",  {24'd0, rx_data}, 32'h00);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
      check("rst_busy",  {31'd0, rx_busy}, 32'd0);
      reset = 1'b0;
      idle(10);

      // Single frame 'h' plus latency from the start edge
      exp_q.push_back(8'h68);
      send_frame(1'b0, C_CPB, 8'h68, 1'b1);
      idle(20);
      check("h_valid_cnt", n_valid, 1);
      check("h_ferr_cnt", n_ferr, 0);
      check("h_busy_after", {31'd0, rx_busy}, 32'd0);
      check("h_data_held", {24'd0, rx_data}, 32'h68);
      check("h_latency_ok",
            {31'd0, ((last_valid_cyc - start_cyc) >= 3 + C_CPB/2 + 9*C_CPB - 1) &&
                    ((last_valid_cyc - start_cyc) <= 3 + C_CPB/2 + 9*C_CPB + 1)}, 32'd1);

      // "hello\n" back to back, zero idle gap
      nv0 = n_valid;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(hello[i]);
         send_frame(1'b0, C_CPB, hello[i], 1'b1);
      end
      idle(40);
      check("hello_valid_cnt", n_valid - nv0, 6);
      check("hello_ferr_cnt", n_ferr, 0);

      // Framing error followed by a held-low line, then a clean 'A'
      nv0 = n_valid;
      nf0 = n_ferr;
      send_frame(1'b0, C_CPB, 8'h55, 1'b0);
      repeat (40) @(negedge clk);
      check("brk_busy_in_hold", {31'd0, rx_busy}, 32'd1);
      idle(20);
      check("brk_ferr_cnt", n_ferr - nf0, 1);
      check("brk_no_valid", n_valid - nv0, 0);
      check("brk_data_kept", {24'd0, rx_data}, 32'h0A);
      check("brk_busy_after", {31'd0, rx_busy}, 32'd0);
      exp_q.push_back(8'h41);
      send_frame(1'b0, C_CPB, 8'h41, 1'b1);
      idle(20);
      check("brk_A_valid", n_valid - nv0, 1);
      check("brk_A_data", {24'd0, rx_data}, 32'h41);
      check("brk_A_ferr", n_ferr - nf0, 1);

      // 5-cycle glitch on an idle line
      nv0 = n_valid;
      nf0 = n_ferr;
      max_busy = 0;
      rx_in = 1'b0;
      repeat (5) @(negedge clk);
      idle(30);
      check("glitch_valid", n_valid - nv0, 0);
      check("glitch_ferr", n_ferr - nf0, 0);
      check("glitch_busy_seen", {31'd0, (max_busy >= 1)}, 32'd1);
      check("glitch_busy_le8", {31'd0, (max_busy <= 8)}, 32'd1);

      // Reset in the middle of data bit 4 of 0xA5
      nv0 = n_valid;
      nf0 = n_ferr;
      begin
         logic [7:0] b;
         b = 8'hA5;
         rx_in = 1'b0;
         repeat (C_CPB) @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            rx_in = b[i];
            repeat (C_CPB) @(negedge clk);
         end
         rx_in = b[4];
         repeat (C_CPB/2) @(negedge clk);
      end
      reset = 1'b1;
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(4 * C_CPB);
      check("rst_mid_no_valid", n_valid - nv0, 0);
      check("rst_mid_no_ferr", n_ferr - nf0, 0);
      check("rst_mid_data", {24'd0, rx_data}, 32'h00);
      exp_q.push_back(8'h3C);
      send_frame(1'b0, C_CPB, 8'h3C, 1'b1);
      idle(20);
      check("rst_3C_valid", n_valid - nv0, 1);
      check("rst_3C_data", {24'd0, rx_data}, 32'h3C);

      // Loopback at the default bit rate
      for (int i = 0; i < 6; i++) begin
         exp_lb_q.push_back(hello[i]);
         send_frame(1'b1, C_CPB_LB, hello[i], 1'b1);
      end
      rx_lb = 1'b1;
      repeat (2 * C_CPB_LB) @(negedge clk);
      check("lb_valid_cnt", n_valid_lb, 6);
      check("lb_ferr_cnt", n_ferr_lb, 0);

      check("exp_q_empty", exp_q.size(), 0);
      check("exp_lb_q_empty", exp_lb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
